// File: rtl/membuf_seq_pkg.sv
// Shared definitions for the buffer sequencer: CSR map, STATUS bit layout and FSM states.
package membuf_seq_pkg;

  localparam logic [4:0] CSR_CTRL   = 5'h00;
  localparam logic [4:0] CSR_STATUS = 5'h04;
  localparam logic [4:0] CSR_SRC    = 5'h08;
  localparam logic [4:0] CSR_DST    = 5'h0C;
  localparam logic [4:0] CSR_LEN    = 5'h10;
  localparam logic [4:0] CSR_COUNT  = 5'h14;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_DONE_BIT    = 1;
  localparam int STATUS_ABORTED_BIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_t;

endpackage

// File: rtl/membuf_seq.sv
// Buffer sequencer: streams LEN words from SRC through an external function unit into DST,
// configured and started through a small CSR file.
module membuf_seq
  import membuf_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              csr_req_i,
  input  logic              csr_we_i,
  input  logic [4:0]        csr_addr_i,
  input  logic [31:0]       csr_wdata_i,
  output logic              csr_resp_o,
  output logic [31:0]       csr_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       fu_x_o,
  input  logic [31:0]       fu_y_i,
  output logic              busy_o,
  output logic              done_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q, sp_q, dp_q;
  logic [LEN_W-1:0]  len_q, rem_q, count_q;
  logic              done_q, aborted_q;
  logic [31:0]       fuX_q;
  logic              csrResp_q;
  logic [31:0]       csrRdata_q;
  logic [31:0]       rdMux;

  logic csrWr, csrRd, ctrlWr, startReq, abortReq;
  logic busy, startRun, startEmpty, abortRun, lastElem;
  logic unusedBits;

  assign csrWr    = csr_req_i & csr_we_i;
  assign csrRd    = csr_req_i & ~csr_we_i;
  assign ctrlWr   = csrWr && (csr_addr_i == CSR_CTRL);
  // Abort takes priority over start when both bits are written together.
  assign abortReq = ctrlWr & csr_wdata_i[CTRL_ABORT_BIT];
  assign startReq = ctrlWr & csr_wdata_i[CTRL_START_BIT] & ~csr_wdata_i[CTRL_ABORT_BIT];

  assign busy       = (state_q != IDLE);
  assign startRun   = startReq && !busy && (len_q != '0);
  assign startEmpty = startReq && !busy && (len_q == '0);
  assign abortRun   = abortReq && busy;
  assign lastElem   = (state_q == WR) && (rem_q == LEN_W'(1));

  assign unusedBits = ^csr_wdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startRun) state_d = RD;
      RD:      state_d = CAP;
      CAP:     state_d = WR;
      WR:      state_d = lastElem ? IDLE : RD;
      default: state_d = IDLE;
    endcase
    if (abortRun) state_d = IDLE;
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    case (state_q)
      RD: mem_addr_o = sp_q;
      WR: begin
        mem_addr_o  = dp_q;
        mem_we_o    = 1'b1;
        mem_wdata_o = fu_y_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      sp_q      <= '0;
      dp_q      <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      fuX_q     <= '0;
    end else begin
      if (csrWr && !busy) begin
        case (csr_addr_i)
          CSR_SRC: src_q <= csr_wdata_i[ADDR_W-1:0];
          CSR_DST: dst_q <= csr_wdata_i[ADDR_W-1:0];
          CSR_LEN: len_q <= csr_wdata_i[LEN_W-1:0];
          default: ;
        endcase
      end
      if (startRun) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
        count_q   <= '0;
        sp_q      <= src_q;
        dp_q      <= dst_q;
        rem_q     <= len_q;
      end
      if (startEmpty) begin
        done_q    <= 1'b1;
        aborted_q <= 1'b0;
      end
      if (state_q == CAP) fuX_q <= mem_rdata_i;
      // A write cycle always retires its element, even when an abort lands on it.
      if (state_q == WR) begin
        sp_q    <= sp_q + ADDR_W'(1);
        dp_q    <= dp_q + ADDR_W'(1);
        count_q <= count_q + LEN_W'(1);
        rem_q   <= rem_q - LEN_W'(1);
        if (lastElem && !abortRun) done_q <= 1'b1;
      end
      if (abortRun) aborted_q <= 1'b1;
    end
  end

  always_comb begin
    rdMux = '0;
    case (csr_addr_i)
      CSR_STATUS: begin
        rdMux[STATUS_BUSY_BIT]    = busy;
        rdMux[STATUS_DONE_BIT]    = done_q;
        rdMux[STATUS_ABORTED_BIT] = aborted_q;
      end
      CSR_SRC:   rdMux[ADDR_W-1:0] = src_q;
      CSR_DST:   rdMux[ADDR_W-1:0] = dst_q;
      CSR_LEN:   rdMux[LEN_W-1:0]  = len_q;
      CSR_COUNT: rdMux[LEN_W-1:0]  = count_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      csrResp_q  <= 1'b0;
      csrRdata_q <= '0;
    end else begin
      csrResp_q  <= csrRd;
      csrRdata_q <= csrRd ? rdMux : '0;
    end
  end

  assign csr_resp_o  = csrResp_q;
  assign csr_rdata_o = csrRdata_q;
  assign fu_x_o      = fuX_q;
  assign busy_o      = busy;
  assign done_o      = done_q;

endmodule
